// File: rtl/alu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if
//   Bundle of the signals exchanged between the multi-cycle sequencing
//   controller and the single-ALU datapath / memory port.
//
//   Datapath -> controller:
//     instruction [31:0]  current instruction-register contents
//     zero                ALU zero flag (meaningful during EXEC)
//     mem_ready           memory completes the current request this cycle
//   Controller -> datapath:
//     ALUop [1:0]         00 add/jal, 01 beq compare, 10 I/load/store, 11 R
//     ir_we, pc_we        instruction register / PC load enables
//     pc_src [1:0]        00 ALU result, 01 branch target, 10 jal target
//     alu_srcA            0 rs1, 1 PC
//     alu_srcB [1:0]      00 rs2, 01 immediate, 10 constant 4
//     mem_req, mem_we     memory request (held until mem_ready) / store
//     mdr_we              latch load data
//     reg_we, wb_sel[1:0] register write / source 00 ALU, 01 MDR, 10 PC
//     illegal             sticky unsupported-opcode flag
//     state [2:0]         current FSM state (debug)
//
//   master : the controller side
//   slave  : the datapath / memory side
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if;
   logic [31:0] instruction;
   logic        zero;
   logic        mem_ready;

   logic [1:0]  ALUop;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        alu_srcA;
   logic [1:0]  alu_srcB;
   logic        mem_req;
   logic        mem_we;
   logic        mdr_we;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic [2:0]  state;

   modport master (
      input  instruction, zero, mem_ready,
      output ALUop, ir_we, pc_we, pc_src, alu_srcA, alu_srcB,
             mem_req, mem_we, mdr_we, reg_we, wb_sel, illegal, state
   );

   modport slave (
      output instruction, zero, mem_ready,
      input  ALUop, ir_we, pc_we, pc_src, alu_srcA, alu_srcB,
             mem_req, mem_we, mdr_we, reg_we, wb_sel, illegal, state
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Multi-cycle sequencing controller for the single-ALU RISC-V datapath.
//   Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, waiting
//   on the memory handshake in FETCH and MEM. One shared ALU is steered to
//   PC increment, address generation or arithmetic through ALUop and the
//   operand selects.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset (forces FETCH, clears illegal)
//     bus  - alu_seq_ctrl_if.master: instruction/zero/mem_ready in, all
//            enables, mux selects, ALUop, illegal and state out
//
//   Supported opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011,
//   BEQ 1100011, JAL 1101111. Anything else traps until reset.
// ---------------------------------------------------------------------------
module alu_seq_ctrl (
   input  logic          clk,
   input  logic          rst,
   alu_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_I,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_JAL,
      CLS_ILL
   } class_e;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_e      state_q;
   state_e      state_d;
   class_e      cls;
   logic [6:0]  opcode;

   logic [1:0]  alu_op;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        mem_req;
   logic        mem_we;
   logic        mdr_we;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        illegal_q;

   // Only the opcode field steers sequencing; funct3/funct7 belong to
   // ALUcontrol, so the upper instruction bits are deliberately ignored.
   logic        unused_instr_bits;
   assign unused_instr_bits = ^bus.instruction[31:7];

   assign opcode = bus.instruction[6:0];

   // Class is recomputed every cycle; the IR only loads in FETCH, so it is
   // stable from DECODE through WB.
   always_comb begin
      cls = CLS_ILL;
      case (opcode)
         OP_R:    cls = CLS_R;
         OP_I:    cls = CLS_I;
         OP_LW:   cls = CLS_LW;
         OP_SW:   cls = CLS_SW;
         OP_BEQ:  cls = CLS_BEQ;
         OP_JAL:  cls = CLS_JAL;
         default: cls = CLS_ILL;
      endcase
   end

   // State register; reset lands in FETCH, never in TRAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Sticky trap flag: set on the DECODE->TRAP transition, cleared only by
   // reset. It rises together with the TRAP state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if (state_d == TRAP) begin
         illegal_q <= 1'b1;
      end
   end

   // Next-state and output decode. Outputs are Moore decodes of state and
   // opcode, except ir_we/pc_we in FETCH, mdr_we and the MEM exit (gated by
   // mem_ready) and pc_we for BEQ (gated by zero).
   always_comb begin
      state_d   = state_q;
      alu_op    = 2'b00;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mdr_we    = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 2'b00;

      case (state_q)
         FETCH: begin
            // Instruction read and PC+4 through the shared ALU.
            mem_req   = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b00;
            pc_src    = 2'b00;
            if (bus.mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end

         DECODE: begin
            state_d = (cls == CLS_ILL) ? TRAP : EXEC;
         end

         EXEC: begin
            case (cls)
               CLS_R: begin
                  alu_src_b = 2'b00;
                  alu_op    = 2'b11;
                  state_d   = WB;
               end
               CLS_I: begin
                  alu_src_b = 2'b01;
                  alu_op    = 2'b10;
                  state_d   = WB;
               end
               CLS_LW, CLS_SW: begin
                  alu_src_b = 2'b01;
                  alu_op    = 2'b10;
                  state_d   = MEM;
               end
               CLS_BEQ: begin
                  alu_src_b = 2'b00;
                  alu_op    = 2'b01;
                  pc_src    = 2'b01;
                  pc_we     = bus.zero;
                  state_d   = FETCH;
               end
               CLS_JAL: begin
                  pc_src    = 2'b10;
                  pc_we     = 1'b1;
                  alu_op    = 2'b00;
                  state_d   = WB;
               end
               default: begin
                  state_d = TRAP;
               end
            endcase
         end

         MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls == CLS_SW);
            if (bus.mem_ready) begin
               if (cls == CLS_LW) begin
                  mdr_we  = 1'b1;
                  state_d = WB;
               end else begin
                  state_d = FETCH;
               end
            end
         end

         WB: begin
            reg_we  = 1'b1;
            state_d = FETCH;
            case (cls)
               CLS_LW:  wb_sel = 2'b01;
               CLS_JAL: wb_sel = 2'b10;
               default: wb_sel = 2'b00;
            endcase
         end

         TRAP: begin
            state_d = TRAP;
         end

         default: begin
            state_d = TRAP;
         end
      endcase
   end

   assign bus.ALUop    = alu_op;
   assign bus.ir_we    = ir_we;
   assign bus.pc_we    = pc_we;
   assign bus.pc_src   = pc_src;
   assign bus.alu_srcA = alu_src_a;
   assign bus.alu_srcB = alu_src_b;
   assign bus.mem_req  = mem_req;
   assign bus.mem_we   = mem_we;
   assign bus.mdr_we   = mdr_we;
   assign bus.reg_we   = reg_we;
   assign bus.wb_sel   = wb_sel;
   assign bus.illegal  = illegal_q;
   assign bus.state    = state_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencing controller for the single-ALU RISC-V datapath. It steps each instruction through fetch, decode, execute, memory and writeback, waiting on a memory handshake where needed. It drives the 2-bit ALUop consumed by ALUcontrol, plus every register/PC/memory enable and datapath mux select. It sits between the instruction register and the shared ALU, so one ALU serves PC increment, address generation and arithmetic.

## Interface
- No parameters; widths come from `define.v` (`InstBus` = 32 bits, `ALUopWidth` = 2).
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- instruction  in  32  current instruction-register contents
- zero  in  1  ALU zero flag, valid during EXEC
- mem_ready  in  1  memory completes the current request this cycle
- ALUop  out  2  00 add/jal, 01 beq compare, 10 I-type/load/store, 11 R-type
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  00 ALU result, 01 branch target, 10 jal target
- alu_srcA  out  1  0 rs1, 1 PC
- alu_srcB  out  2  00 rs2, 01 immediate, 10 constant 4
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store (valid only with mem_req)
- mdr_we  out  1  latch load data
- reg_we  out  1  register-file write
- wb_sel  out  2  00 ALU result register, 01 MDR, 10 PC (link)
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  current FSM state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Instruction classes, decoded from opcode = instruction[6:0]:
  - R = 0110011
  - I = 0010011
  - LW = 0000011
  - SW = 0100011
  - BEQ = 1100011
  - JAL = 1101111
  - anything else is illegal
- Unless stated otherwise below, every output is 0 in every state.
- FETCH:
  - mem_req=1, alu_srcA=1, alu_srcB=10, ALUop=00, pc_src=00.
  - When mem_ready=1: ir_we=1 and pc_we=1 (PC←PC+4), then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Single cycle; no enables asserted.
  - Illegal opcode → TRAP; any other opcode → EXEC.
- EXEC, by class:
  - R: alu_srcB=00, ALUop=11 → WB.
  - I: alu_srcB=01, ALUop=10 → WB.
  - LW/SW: alu_srcB=01, ALUop=10 (address) → MEM.
  - BEQ: alu_srcB=00, ALUop=01, pc_src=01, pc_we=zero → FETCH.
  - JAL: pc_src=10, pc_we=1, ALUop=00 → WB.
- MEM:
  - mem_req=1; mem_we=1 for SW.
  - When mem_ready=1: LW asserts mdr_we=1 and goes to WB; SW goes to FETCH.
  - Otherwise hold mem_req and mem_we and stay in MEM.
- WB:
  - reg_we=1 with wb_sel: R/I → 00, LW → 01, JAL → 10. Then → FETCH.
  - Writes to rd=x0 are still signalled; the register file discards them.
- TRAP:
  - illegal=1; all enables 0.
  - Stays in TRAP until rst. Leaving TRAP requires rst.
- The instruction class is recomputed from `instruction` every cycle. The IR is stable from DECODE through WB because ir_we is asserted only in FETCH.
- ALUop matches ALUcontrol's funct3/funct7 decode. This block never inspects funct3 or funct7.

## Timing
- Outputs are Moore decodes of the registered state and the current opcode. The exceptions are ir_we, pc_we (in FETCH), mdr_we and the MEM exit, which are also gated combinationally by mem_ready or zero.
- Asserting rst at any time, including mid-MEM with mem_req high, sends the FSM to FETCH (not TRAP) on the same edge. Reset values: state=0, illegal=0.
  - FETCH decode then applies immediately: mem_req=1, alu_srcA=1, alu_srcB=10, ALUop=00, pc_src=00, ir_we=pc_we=0 (with mem_ready=0); all other outputs 0.
  - The first fetch request is issued in the first cycle after rst deasserts.
- Cycles per instruction with mem_ready tied high: BEQ 3, R/I 4, SW 4, JAL 4, LW 5.
- Each wait cycle (mem_ready=0) adds exactly one cycle in FETCH or MEM.
- Handshake: mem_req stays high and mem_we stays constant until the cycle in which mem_ready=1; that cycle completes the transfer. A mem_ready seen outside FETCH/MEM is ignored.
- BEQ with zero=0: pc_we=0, so the PC keeps the PC+4 value written in FETCH.
- zero is sampled only in the EXEC cycle of a BEQ.

## Test plan
- Reset mid-MEM: rst asserted in MEM of a LW with mem_ready=0 → state=0 on that edge, mem_req=1, mdr_we=0, reg_we=0. The next fetch issues after rst deasserts.
- R-type add (instruction 0x002081B3), mem_ready=1 → states 0,1,2,4. ALUop=11 in EXEC; reg_we=1 with wb_sel=00 in WB; 4 cycles total.
- LW (0x0000A183) with mem_ready low for 2 cycles in MEM → mem_req held 3 cycles; mdr_we pulses once; WB has wb_sel=01; 7 cycles total.
- BEQ (0x00208463) run twice, with zero=1 then zero=0 → pc_we=1 with pc_src=01 in the first EXEC, pc_we=0 in the second; each instruction takes 3 cycles.
- JAL (0x008000EF) → EXEC: pc_we=1, pc_src=10. WB: reg_we=1, wb_sel=10.
- Illegal opcode 0x0000007F → DECODE goes to TRAP. illegal=1 and state=7 persist for 100 cycles with all enables 0; rst clears both.
